// File: rtl/bp_fe_queue_endpoint.sv
// rtl/bp_fe_queue_endpoint.sv - FE queue endpoint: fetch-to-BE FIFO plus BE command handler with redirect pulse
module bp_fe_queue_endpoint #(
    parameter int vaddr_width_p = 39,
    parameter int queue_els_p   = 8,
    localparam int fe_queue_width_lp = vaddr_width_p + 33,
    localparam int fe_cmd_width_lp   = vaddr_width_p + 3
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         fetch_v_i,
    input  logic [vaddr_width_p-1:0]     fetch_pc_i,
    input  logic [31:0]                  fetch_instr_i,
    input  logic                         fetch_exception_i,
    output logic                         fetch_ready_o,
    output logic [fe_queue_width_lp-1:0] fe_queue_o,
    output logic                         fe_queue_v_o,
    input  logic                         fe_queue_ready_i,
    input  logic [fe_cmd_width_lp-1:0]   fe_cmd_i,
    input  logic                         fe_cmd_v_i,
    output logic                         fe_cmd_yumi_o,
    output logic                         redirect_v_o,
    output logic [vaddr_width_p-1:0]     redirect_pc_o
);

    localparam int ptr_w_lp = $clog2(queue_els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(queue_els_p);

    typedef enum logic [1:0] {
        e_reset = 2'd0,
        e_run   = 2'd1,
        e_wait  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [ptr_w_lp-1:0]      rptr_q, rptr_d;
    logic [ptr_w_lp-1:0]      wptr_q, wptr_d;
    logic [cnt_w_lp-1:0]      count_q, count_d;
    logic                     redirect_v_q, redirect_v_d;
    logic [vaddr_width_p-1:0] redirect_pc_q, redirect_pc_d;
    logic [fe_queue_width_lp-1:0] mem_q [queue_els_p];

    logic                     full, empty, enq, deq, flush;
    logic [2:0]               cmd_opcode;
    logic [vaddr_width_p-1:0] cmd_npc;

    assign cmd_opcode = fe_cmd_i[2:0];
    assign cmd_npc    = fe_cmd_i[fe_cmd_width_lp-1:3];
    assign full       = (count_q == full_cnt_lp);
    assign empty      = (count_q == '0);

    // A pending command blocks both queue ports so a flush never races an enqueue/dequeue.
    assign fe_cmd_yumi_o = fe_cmd_v_i;
    assign fetch_ready_o = (state_q == e_run) & ~full & ~fe_cmd_v_i;
    assign fe_queue_v_o  = ~empty & ~fe_cmd_v_i;
    assign fe_queue_o    = mem_q[rptr_q];
    assign enq           = fetch_v_i & fetch_ready_o;
    assign deq           = fe_queue_v_o & fe_queue_ready_i;
    assign redirect_v_o  = redirect_v_q;
    assign redirect_pc_o = redirect_pc_q;

    always_comb begin
        state_d       = state_q;
        redirect_v_d  = 1'b0;
        redirect_pc_d = redirect_pc_q;
        flush         = 1'b0;
        if (fe_cmd_v_i) begin
            case (cmd_opcode)
                3'd0: begin
                    flush         = 1'b1;
                    state_d       = e_run;
                    redirect_v_d  = 1'b1;
                    redirect_pc_d = cmd_npc;
                end
                3'd1: begin
                    if (state_q != e_reset) begin
                        flush         = 1'b1;
                        state_d       = e_run;
                        redirect_v_d  = 1'b1;
                        redirect_pc_d = cmd_npc;
                    end
                end
                3'd2: begin
                    if (state_q != e_reset) begin
                        flush   = 1'b1;
                        state_d = e_wait;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq) wptr_d = wptr_q + ptr_w_lp'(1);
            if (deq) rptr_d = rptr_q + ptr_w_lp'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + cnt_w_lp'(1);
                2'b01:   count_d = count_q - cnt_w_lp'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= e_reset;
            rptr_q        <= '0;
            wptr_q        <= '0;
            count_q       <= '0;
            redirect_v_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            count_q       <= count_d;
            redirect_v_q  <= redirect_v_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Storage is left unreset; only pointers/occupancy define what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= {fetch_exception_i, fetch_pc_i, fetch_instr_i};
    end

endmodule

// File: tb/tb_bp_fe_queue_endpoint.sv
// tb/tb_bp_fe_queue_endpoint.sv - directed self-checking bench for bp_fe_queue_endpoint
module tb_bp_fe_queue_endpoint;

    localparam int va_lp = 39;
    localparam int qw_lp = va_lp + 33;
    localparam int cw_lp = va_lp + 3;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              fetch_v_i = 1'b0;
    logic [va_lp-1:0]  fetch_pc_i = '0;
    logic [31:0]       fetch_instr_i = '0;
    logic              fetch_exception_i = 1'b0;
    logic              fetch_ready_o;
    logic [qw_lp-1:0]  fe_queue_o;
    logic              fe_queue_v_o;
    logic              fe_queue_ready_i = 1'b0;
    logic [cw_lp-1:0]  fe_cmd_i = '0;
    logic              fe_cmd_v_i = 1'b0;
    logic              fe_cmd_yumi_o;
    logic              redirect_v_o;
    logic [va_lp-1:0]  redirect_pc_o;

    int vectors = 0;
    int miscompares = 0;
    logic [qw_lp-1:0] model_q[$];

    bp_fe_queue_endpoint dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .fetch_v_i         (fetch_v_i),
        .fetch_pc_i        (fetch_pc_i),
        .fetch_instr_i     (fetch_instr_i),
        .fetch_exception_i (fetch_exception_i),
        .fetch_ready_o     (fetch_ready_o),
        .fe_queue_o        (fe_queue_o),
        .fe_queue_v_o      (fe_queue_v_o),
        .fe_queue_ready_i  (fe_queue_ready_i),
        .fe_cmd_i          (fe_cmd_i),
        .fe_cmd_v_i        (fe_cmd_v_i),
        .fe_cmd_yumi_o     (fe_cmd_yumi_o),
        .redirect_v_o      (redirect_v_o),
        .redirect_pc_o     (redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [qw_lp-1:0] entry(input logic exc, input logic [va_lp-1:0] pc,
                                               input logic [31:0] instr);
        return {exc, pc, instr};
    endfunction

    // Present a command for one cycle, checking the same-cycle handshake and port blocking.
    task automatic cmd_cycle(input logic [2:0] op, input logic [va_lp-1:0] npc);
        fe_cmd_v_i = 1'b1;
        fe_cmd_i   = {npc, op};
        #1;
        check("cmd_yumi", fe_cmd_yumi_o, 1'b1);
        check("cmd_qv_blocked", fe_queue_v_o, 1'b0);
        check("cmd_rdy_blocked", fetch_ready_o, 1'b0);
        @(negedge clk_i);
        fe_cmd_v_i = 1'b0;
        #1;
    endtask

    task automatic push(input logic [va_lp-1:0] pc, input logic [31:0] instr, input logic exc);
        fetch_v_i = 1'b1;
        fetch_pc_i = pc;
        fetch_instr_i = instr;
        fetch_exception_i = exc;
        #1;
        check("push_ready", fetch_ready_o, 1'b1);
        @(negedge clk_i);
        fetch_v_i = 1'b0;
        model_q.push_back(entry(exc, pc, instr));
        #1;
    endtask

    task automatic pop();
        fe_queue_ready_i = 1'b1;
        #1;
        check("pop_valid", fe_queue_v_o, 1'b1);
        check("pop_data", fe_queue_o, model_q[0]);
        void'(model_q.pop_front());
        @(negedge clk_i);
        fe_queue_ready_i = 1'b0;
        #1;
    endtask

    initial begin
        // Reset values, and commands during reset.
        @(negedge clk_i);
        fe_cmd_v_i = 1'b1;
        fe_cmd_i = {39'h1111, 3'd0};
        #1;
        check("rst_ready", fetch_ready_o, 1'b0);
        check("rst_qv", fe_queue_v_o, 1'b0);
        check("rst_rv", redirect_v_o, 1'b0);
        check("rst_rpc", redirect_pc_o, 0);
        check("rst_yumi", fe_cmd_yumi_o, 1'b1);
        @(negedge clk_i);
        fe_cmd_v_i = 1'b0;
        #1;
        check("rst_cmd_noeffect", redirect_v_o, 1'b0);
        reset_i = 1'b0;
        @(negedge clk_i);

        // In e_reset, opcodes 1 and 2 are ignored.
        cmd_cycle(3'd1, 39'h1234);
        check("ereset_op1_rv", redirect_v_o, 1'b0);
        check("ereset_op1_rdy", fetch_ready_o, 1'b0);
        cmd_cycle(3'd2, 39'h0);
        check("ereset_op2_rdy", fetch_ready_o, 1'b0);

        // Opcode 0 starts the frontend.
        cmd_cycle(3'd0, 39'h8000_0000);
        check("start_rv", redirect_v_o, 1'b1);
        check("start_rpc", redirect_pc_o, 39'h8000_0000);
        check("start_ready", fetch_ready_o, 1'b1);
        @(negedge clk_i); #1;
        check("start_rv_pulse", redirect_v_o, 1'b0);
        check("start_ready2", fetch_ready_o, 1'b1);

        // Fill to full, then drain in order.
        for (int i = 0; i < 8; i++) push(39'h100 + 39'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
        check("full_ready", fetch_ready_o, 1'b0);
        check("full_qv", fe_queue_v_o, 1'b1);
        fetch_v_i = 1'b1;
        @(negedge clk_i);
        fetch_v_i = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) pop();
        check("drain_qv", fe_queue_v_o, 1'b0);

        // Redirect flushes a partially full queue.
        for (int i = 0; i < 3; i++) push(39'h200 + 39'(4 * i), 32'hB000_0000 + 32'(i), 1'b0);
        cmd_cycle(3'd1, 39'h2000);
        model_q.delete();
        check("redir_qv", fe_queue_v_o, 1'b0);
        check("redir_rv", redirect_v_o, 1'b1);
        check("redir_rpc", redirect_pc_o, 39'h2000);

        // Nop opcode leaves queue and state alone.
        @(negedge clk_i); #1;
        push(39'h300, 32'hC000_0000, 1'b0);
        cmd_cycle(3'd5, 39'h7777);
        check("nop_qv", fe_queue_v_o, 1'b1);
        check("nop_rv", redirect_v_o, 1'b0);
        check("nop_ready", fetch_ready_o, 1'b1);

        // Wait: flush and hold off fetch until redirected.
        cmd_cycle(3'd2, 39'h0);
        model_q.delete();
        check("wait_rv", redirect_v_o, 1'b0);
        fetch_v_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("wait_ready", fetch_ready_o, 1'b0);
            check("wait_qv", fe_queue_v_o, 1'b0);
            @(negedge clk_i); #1;
        end
        fetch_v_i = 1'b0;
        cmd_cycle(3'd1, 39'h3000);
        check("unwait_rv", redirect_v_o, 1'b1);
        check("unwait_rpc", redirect_pc_o, 39'h3000);
        check("unwait_ready", fetch_ready_o, 1'b1);
        check("unwait_qv", fe_queue_v_o, 1'b0);

        // Steady state at occupancy 4 with pointer wrap and exception entries.
        for (int i = 0; i < 4; i++) push(39'h400 + 39'(4 * i), 32'hD000_0000 + 32'(i), (i == 2));
        for (int i = 0; i < 16; i++) begin
            fetch_v_i = 1'b1;
            fetch_pc_i = 39'h500 + 39'(4 * i);
            fetch_instr_i = 32'hE000_0000 + 32'(i);
            fetch_exception_i = (i % 3 == 0);
            fe_queue_ready_i = 1'b1;
            #1;
            check("ss_ready", fetch_ready_o, 1'b1);
            check("ss_qv", fe_queue_v_o, 1'b1);
            check("ss_data", fe_queue_o, model_q[0]);
            if (i == 2) check("ss_exc_bit", fe_queue_o[qw_lp-1], 1'b1);
            void'(model_q.pop_front());
            model_q.push_back(entry(fetch_exception_i, fetch_pc_i, fetch_instr_i));
            @(negedge clk_i);
        end
        fetch_v_i = 1'b0;
        fe_queue_ready_i = 1'b0;
        fetch_exception_i = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) pop();
        check("ss_occ4_empty", fe_queue_v_o, 1'b0);

        // Asynchronous reset mid-stream discards queued entries.
        for (int i = 0; i < 5; i++) push(39'h600 + 39'(4 * i), 32'hF000_0000 + 32'(i), 1'b0);
        check("pre_rst_qv", fe_queue_v_o, 1'b1);
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_qv", fe_queue_v_o, 1'b0);
        check("arst_ready", fetch_ready_o, 1'b0);
        model_q.delete();
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        cmd_cycle(3'd1, 39'h5000);
        check("arst_op1_rv", redirect_v_o, 1'b0);
        check("arst_op1_ready", fetch_ready_o, 1'b0);
        cmd_cycle(3'd0, 39'h6000);
        check("arst_op0_rv", redirect_v_o, 1'b1);
        check("arst_op0_rpc", redirect_pc_o, 39'h6000);
        check("arst_op0_qv", fe_queue_v_o, 1'b0);

        // Back-to-back redirects, then reset kills a pending pulse.
        cmd_cycle(3'd1, 39'h7000);
        fe_cmd_v_i = 1'b1;
        fe_cmd_i = {39'h7100, 3'd0};
        #1;
        check("b2b_rpc1", redirect_pc_o, 39'h7000);
        @(negedge clk_i);
        fe_cmd_v_i = 1'b0;
        #1;
        check("b2b_rv2", redirect_v_o, 1'b1);
        check("b2b_rpc2", redirect_pc_o, 39'h7100);
        reset_i = 1'b1;
        #1;
        check("arst_rv", redirect_v_o, 1'b0);
        check("arst_rpc", redirect_pc_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bp_fe_queue_endpoint.md
BP_FE_QUEUE_ENDPOINT -- requirements
Module: bp_fe_queue_endpoint

Interface
REQ-001 SHALL have parameter vaddr_width_p, default 39, meaning virtual PC width.
REQ-002 SHALL have parameter queue_els_p, default 8, meaning FE queue depth; power of two, ≥2.
REQ-003 SHALL have localparam fe_queue_width_lp = vaddr_width_p+33, meaning {msg_type[1], pc[vaddr_width_p], instr[32]} with instr in LSBs.
REQ-004 SHALL have localparam fe_cmd_width_lp = vaddr_width_p+3, meaning {npc[vaddr_width_p], opcode[3]} with opcode in LSBs.
REQ-005 clk_i  in  1  sole clock; all state on rising edge.
REQ-006 reset_i  in  1  asynchronous, active-high reset.
REQ-007 fetch_v_i  in  1  fetched instruction valid.
REQ-008 fetch_pc_i  in  vaddr_width_p  PC of fetched instruction.
REQ-009 fetch_instr_i  in  32  fetched instruction.
REQ-010 fetch_exception_i  in  1  entry is an exception message (msg_type=1).
REQ-011 fetch_ready_o  out  1  endpoint accepts fetch this cycle.
REQ-012 fe_queue_o  out  fe_queue_width_lp  head entry toward BE.
REQ-013 fe_queue_v_o  out  1  head entry valid.
REQ-014 fe_queue_ready_i  in  1  BE accepts head (ready/valid).
REQ-015 fe_cmd_i  in  fe_cmd_width_lp  command from BE director.
REQ-016 fe_cmd_v_i  in  1  command valid.
REQ-017 fe_cmd_yumi_o  out  1  command consumed this cycle.
REQ-018 redirect_v_o  out  1  one-cycle redirect pulse to fetch PC generator.
REQ-019 redirect_pc_o  out  vaddr_width_p  redirect target.

Function
REQ-020 FSM states SHALL be e_reset, e_run, e_wait; reset state e_reset.
REQ-021 Opcodes SHALL be 0=state_reset, 1=pc_redirect, 2=wait; 3-7 = nop (consumed, no state change, no flush).
REQ-022 fe_cmd_yumi_o SHALL equal fe_cmd_v_i combinationally in every state (one command per cycle, never back-pressured).
REQ-023 On consuming opcode 0 or 1, SHALL flush queue, enter e_run, and assert redirect_v_o the following cycle with redirect_pc_o = consumed npc.
REQ-024 On consuming opcode 2, SHALL flush queue and enter e_wait; no redirect pulse.
REQ-025 In e_reset, opcodes 1 and 2 SHALL be consumed and ignored (no flush, no redirect, stay e_reset).
REQ-026 In e_wait, only opcodes 0/1 leave the state (to e_run).
REQ-027 redirect_v_o SHALL be a registered single-cycle pulse; back-to-back redirects yield back-to-back pulses, each carrying its own npc.
REQ-028 fetch_ready_o SHALL = (state==e_run) & ~full & ~fe_cmd_v_i.
REQ-029 Enqueue SHALL occur on fetch_v_i & fetch_ready_o; entry = {fetch_exception_i, fetch_pc_i, fetch_instr_i}.
REQ-030 fe_queue_v_o SHALL = ~empty & ~fe_cmd_v_i; fe_queue_o SHALL be head entry, valid-qualified only.
REQ-031 Dequeue SHALL occur on fe_queue_v_o & fe_queue_ready_i; first-in first-out order.
REQ-032 Enqueue latency: entry visible at fe_queue_o the cycle after enqueue (no bypass when empty).
REQ-033 Simultaneous enqueue and dequeue SHALL keep occupancy constant; allowed at any occupancy except full (no enqueue when full).
REQ-034 Read/write pointers SHALL be log2(queue_els_p) bits and wrap modulo queue_els_p; occupancy counter log2(queue_els_p)+1 bits, range 0..queue_els_p.
REQ-035 Flush SHALL zero pointers and occupancy in one cycle; flush takes precedence over any same-cycle enqueue/dequeue (which are already blocked by REQ-028/030).

Reset
REQ-036 On reset_i assertion, asynchronously: state=e_reset, pointers/occupancy=0, redirect_v_o=0, redirect_pc_o=0.
REQ-037 Outputs during reset: fetch_ready_o=0, fe_queue_v_o=0; fe_cmd_yumi_o follows fe_cmd_v_i but command SHALL have no effect while reset_i high.
REQ-038 Reset mid-operation SHALL discard all queued entries and any pending redirect pulse.

Verification
REQ-039 Reset, then cmd opcode 0 npc=0x8000_0000 -> yumi same cycle; next cycle redirect_v_o=1, redirect_pc_o=0x8000_0000; fetch_ready_o=1 thereafter.
REQ-040 In e_run, fe_queue_ready_i=0, push 8 fetches PC 0x100..0x11C -> fetch_ready_o=0 after 8th; raise ready -> pops in order 0x100..0x11C, then fe_queue_v_o=0.
REQ-041 Queue holding 3 entries, cmd opcode 1 npc=0x2000 -> fe_queue_v_o=0 and fetch_ready_o=0 that cycle; next cycle queue empty, redirect pulse 0x2000.
REQ-042 Cmd opcode 2 -> flush, fetch_ready_o stays 0 for 20 cycles; then opcode 1 npc=0x3000 -> redirect pulse 0x3000, fetch_ready_o=1.
REQ-043 Occupancy 4, enqueue and dequeue every cycle for 16 cycles with wrap -> occupancy stays 4, order preserved; exception fetch yields msg_type bit=1.
REQ-044 Assert reset_i asynchronously mid-stream with 5 entries queued -> fe_queue_v_o=0 immediately, state e_reset; opcode 1 before opcode 0 ignored.
